// File: rtl/fifo_axis_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_bridge (with generic_fifo, fifo_to_axis)
//  Description : Buffered FIFO-to-AXI4-Stream master bridge. Producer beats
//                {last, keep, data} go through a circular FIFO and are then
//                prefetched into a small skid buffer that drives the AXIS
//                master with full back-pressure support.
//  Revision    : 1.0 - initial release
// ============================================================================

module generic_fifo #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             full,
   output logic             empty
);
   localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
   localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
   localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic [c_PTR_W:0]   w_count_next;
   logic               r_full;
   logic               r_empty;
   logic               w_wr_accept;
   logic               w_rd_accept;

   // Writes while full are dropped even if a read frees a slot this cycle.
   assign w_wr_accept = wr_en && !r_full;
   assign w_rd_accept = rd_en && !r_empty;
   assign full        = r_full;
   assign empty       = r_empty;

   // Next occupancy; simultaneous read and write cancel out.
   always_comb begin
      w_count_next = r_count;
      case ({w_wr_accept, w_rd_accept})
         2'b10:   w_count_next = r_count + c_CNT_ONE;
         2'b01:   w_count_next = r_count - c_CNT_ONE;
         default: w_count_next = r_count;
      endcase
   end

   // Pointers, count and flags; flags are registered from the next count so
   // they change on the same edge as the count itself.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_wr_accept) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_rd_accept) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         r_count <= w_count_next;
         r_full  <= (w_count_next == c_CNT_FULL);
         r_empty <= (w_count_next == '0);
      end
   end

   // Storage array write port.
   always_ff @(posedge clock) begin
      if (w_wr_accept) r_mem[r_wr_ptr] <= din;
   end

   // Registered read port with a one-cycle valid pulse per accepted read.
   always_ff @(posedge clock) begin
      if (reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= w_rd_accept;
         if (w_rd_accept) dout <= r_mem[r_rd_ptr];
      end
   end
endmodule

module fifo_to_axis #(
   parameter int WIDTH        = 128,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [WIDTH+WIDTH/8:0]         fifo_dout,
   input  logic                           fifo_dout_valid,
   input  logic                           fifo_empty,
   output logic                           rd_en,
   output logic                           m_axis_tvalid,
   output logic [WIDTH-1:0]               m_axis_tdata,
   output logic [WIDTH/8-1:0]             m_axis_tkeep,
   output logic                           m_axis_tlast,
   input  logic                           m_axis_tready
);
   localparam int                   c_KEEP_W   = WIDTH / 8;
   localparam int                   c_ENTRY_W  = WIDTH + c_KEEP_W + 1;
   localparam int                   c_BPTR_W   = $clog2(BUFFER_DEPTH);
   localparam int                   c_OCC_W    = $clog2(BUFFER_DEPTH + 1);
   localparam logic [c_BPTR_W-1:0]  c_BPTR_ONE = c_BPTR_W'(1);
   localparam logic [c_BPTR_W-1:0]  c_BPTR_END = c_BPTR_W'(BUFFER_DEPTH - 1);
   localparam logic [c_OCC_W-1:0]   c_OCC_ONE  = c_OCC_W'(1);
   localparam logic [c_OCC_W:0]     c_BUF_LIM  = (c_OCC_W + 1)'(BUFFER_DEPTH);

   logic [c_ENTRY_W-1:0] r_buf [BUFFER_DEPTH];
   logic [c_BPTR_W-1:0]  r_wr_ptr;
   logic [c_BPTR_W-1:0]  r_rd_ptr;
   logic [c_OCC_W-1:0]   r_occ;
   logic                 r_in_flight;
   logic [c_OCC_W:0]     w_pending;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_valid;
   logic [c_ENTRY_W-1:0] w_head;

   // Reserve a slot for every read still in flight so the buffer never overflows.
   assign w_pending = {1'b0, r_occ} + {{c_OCC_W{1'b0}}, r_in_flight};
   assign rd_en     = !fifo_empty && (w_pending < c_BUF_LIM);

   assign w_valid = (r_occ != '0);
   assign w_push  = fifo_dout_valid;
   assign w_pop   = w_valid && m_axis_tready;
   assign w_head  = r_buf[r_rd_ptr];

   // Head entry unpacked from {last, keep, data}; zero while no beat is held.
   assign m_axis_tvalid = w_valid;
   assign m_axis_tdata  = w_valid ? w_head[WIDTH-1:0] : '0;
   assign m_axis_tkeep  = w_valid ? w_head[WIDTH +: c_KEEP_W] : '0;
   assign m_axis_tlast  = w_valid ? w_head[c_ENTRY_W-1] : 1'b0;

   // Skid buffer pointers, occupancy and in-flight tracking.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_occ       <= '0;
         r_in_flight <= 1'b0;
      end else begin
         r_in_flight <= rd_en;
         if (w_push) r_wr_ptr <= (r_wr_ptr == c_BPTR_END) ? '0 : r_wr_ptr + c_BPTR_ONE;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_BPTR_END) ? '0 : r_rd_ptr + c_BPTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + c_OCC_ONE;
            2'b01:   r_occ <= r_occ - c_OCC_ONE;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Skid buffer storage; captures each entry returned by the FIFO.
   always_ff @(posedge clock) begin
      if (w_push) r_buf[r_wr_ptr] <= fifo_dout;
   end
endmodule

module fifo_axis_bridge #(
   parameter int DATA_WIDTH   = 128,
   parameter int FIFO_DEPTH   = 32,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_keep,
   input  logic                    wr_last,
   output logic                    wr_full,
   output logic                    fifo_empty,
   output logic                    m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready
);
   localparam int c_ENTRY_W = DATA_WIDTH + DATA_WIDTH / 8 + 1;

   logic [c_ENTRY_W-1:0] w_fifo_din;
   logic [c_ENTRY_W-1:0] w_fifo_dout;
   logic                 w_fifo_dout_valid;
   logic                 w_fifo_rd_en;
   logic                 w_fifo_empty;

   assign w_fifo_din = {wr_last, wr_keep, wr_data};
   assign fifo_empty = w_fifo_empty;

   generic_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (c_ENTRY_W)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .wr_en      (wr_en),
      .din        (w_fifo_din),
      .rd_en      (w_fifo_rd_en),
      .dout       (w_fifo_dout),
      .dout_valid (w_fifo_dout_valid),
      .full       (wr_full),
      .empty      (w_fifo_empty)
   );

   fifo_to_axis #(
      .WIDTH        (DATA_WIDTH),
      .BUFFER_DEPTH (BUFFER_DEPTH)
   ) u_adapter (
      .clock           (clock),
      .reset           (reset),
      .fifo_dout       (w_fifo_dout),
      .fifo_dout_valid (w_fifo_dout_valid),
      .fifo_empty      (w_fifo_empty),
      .rd_en           (w_fifo_rd_en),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tkeep    (m_axis_tkeep),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tready   (m_axis_tready)
   );
endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_axis_bridge
//  Description : Directed self-checking bench for fifo_axis_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_fifo_axis_bridge;
   localparam int DW = 128;
   localparam int KW = DW / 8;

   logic          clock;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic [KW-1:0] wr_keep;
   logic          wr_last;
   logic          wr_full;
   logic          fifo_empty;
   logic          m_axis_tvalid;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tlast;
   logic          m_axis_tready;

   int n_checks = 0;
   int n_errors = 0;

   fifo_axis_bridge #(
      .DATA_WIDTH   (DW),
      .FIFO_DEPTH   (32),
      .BUFFER_DEPTH (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .wr_keep       (wr_keep),
      .wr_last       (wr_last),
      .wr_full       (wr_full),
      .fifo_empty    (fifo_empty),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle just after it.
   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   // Back-pressure beat pattern, {last, keep, data} for beat index i (1-based).
   function automatic logic [DW+KW:0] bp_beat(input int i);
      logic [31:0] w;
      logic [7:0]  b;
      w = 32'hC0DE0000 ^ 32'(i);
      b = 8'(i);
      return {(i % 8) == 0, b, ~b, w, ~w, w, ~w};
   endfunction

   function automatic logic [DW+KW:0] out_beat();
      return {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
   endfunction

   logic [DW-1:0]   burst [5];
   logic [31:0]     lfsr;
   logic [DW+KW:0]  sb [$];
   logic [DW+KW:0]  exp_beat;
   logic [DW+KW:0]  wbeat;
   int              rcv;
   int              sent;
   int              seen;

   initial begin
      reset         = 1'b1;
      wr_en         = 1'b0;
      wr_data       = '0;
      wr_keep       = '0;
      wr_last       = 1'b0;
      m_axis_tready = 1'b0;

      // ---------------- reset with random inputs ----------------
      for (int i = 0; i < 100; i++) begin
         wr_en         = 1'($urandom);
         wr_data       = {$urandom, $urandom, $urandom, $urandom};
         wr_keep       = 16'($urandom);
         wr_last       = 1'($urandom);
         m_axis_tready = 1'($urandom);
         tick();
      end
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_empty",  fifo_empty, 1);
      chk("rst_full",   wr_full, 0);
      chk("rst_tdata",  m_axis_tdata, 0);
      chk("rst_tkeep",  m_axis_tkeep, 0);
      chk("rst_tlast",  m_axis_tlast, 0);
      reset = 1'b0;
      wr_en = 1'b0;
      m_axis_tready = 1'b0;
      tick();
      chk("idle_tvalid", m_axis_tvalid, 0);

      // ---------------- single beat, 2-cycle latency ----------------
      m_axis_tready = 1'b1;
      wr_en   = 1'b1;
      wr_data = 128'h0123456789ABCDEF0123456789ABCDEF;
      wr_keep = 16'hFFFF;
      wr_last = 1'b1;
      tick();                                  // edge k
      wr_en = 1'b0;
      chk("single_empty_k",  fifo_empty, 0);
      chk("single_tvalid_k", m_axis_tvalid, 0);
      tick();                                  // edge k+1
      chk("single_tvalid_k1", m_axis_tvalid, 0);
      chk("single_empty_k1",  fifo_empty, 1);
      tick();                                  // edge k+2
      chk("single_tvalid_k2", m_axis_tvalid, 1);
      chk("single_beat", out_beat(), {1'b1, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF});
      tick();                                  // edge k+3
      chk("single_tvalid_k3", m_axis_tvalid, 0);

      // ---------------- 5-beat PRBS burst, tready high ----------------
      lfsr = 32'hFFFFFFFF;
      for (int b = 0; b < 5; b++) begin
         for (int w = 0; w < 4; w++) begin
            lfsr = lfsr_step(lfsr);
            burst[b][w*32 +: 32] = lfsr;
         end
      end
      for (int i = 0; i < 7; i++) begin
         if (i < 5) begin
            wr_en   = 1'b1;
            wr_data = burst[i];
            wr_keep = 16'hFFFF;
            wr_last = (i == 4);
         end else begin
            wr_en = 1'b0;
         end
         tick();
         if (i >= 2) begin
            chk("burst_tvalid", m_axis_tvalid, 1);
            chk("burst_tdata",  m_axis_tdata, burst[i-2]);
            chk("burst_tlast",  m_axis_tlast, (i == 6));
         end else begin
            chk("burst_tvalid_pre", m_axis_tvalid, 0);
         end
      end
      wr_en = 1'b0;
      tick();
      chk("burst_done_tvalid", m_axis_tvalid, 0);
      chk("burst_done_empty",  fifo_empty, 1);

      // ---------------- back-pressure: 40 writes, tready low ----------------
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         wbeat   = bp_beat(i);
         wr_en   = 1'b1;
         wr_data = wbeat[DW-1:0];
         wr_keep = wbeat[DW +: KW];
         wr_last = wbeat[DW+KW];
         tick();
         chk("bp_full", wr_full, (i >= 36));
         if (i >= 3) chk("bp_stall_beat", out_beat(), bp_beat(1));
      end
      wr_en = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("bp_hold_tvalid", m_axis_tvalid, 1);
      chk("bp_hold_beat",   out_beat(), bp_beat(1));
      chk("bp_hold_full",   wr_full, 1);

      m_axis_tready = 1'b1;
      rcv = 0;
      for (int c = 0; c < 200 && rcv < 36; c++) begin
         if (m_axis_tvalid) begin
            chk("bp_drain_beat", out_beat(), bp_beat(rcv + 1));
            rcv++;
         end
         tick();
      end
      chk("bp_drain_count", rcv, 36);
      for (int i = 0; i < 4; i++) tick();
      chk("bp_drain_tvalid", m_axis_tvalid, 0);
      chk("bp_drain_empty",  fifo_empty, 1);
      chk("bp_drain_full",   wr_full, 0);

      // ---------------- random tready, 1000 beats, scoreboard ----------------
      sent = 0;
      rcv  = 0;
      for (int c = 0; c < 20000 && rcv < 1000; c++) begin
         wr_en   = (sent < 1000) && ($urandom_range(0, 3) != 0);
         wr_data = {$urandom, $urandom, $urandom, $urandom};
         wr_keep = 16'($urandom);
         wr_last = 1'($urandom);
         if (wr_en && !wr_full) begin
            sb.push_back({wr_last, wr_keep, wr_data});
            sent++;
         end
         m_axis_tready = 1'($urandom);
         if (m_axis_tvalid && m_axis_tready) begin
            exp_beat = (sb.size() > 0) ? sb.pop_front() : '0;
            chk("rand_beat", out_beat(), exp_beat);
            rcv++;
         end
         tick();
      end
      wr_en = 1'b0;
      chk("rand_count", rcv, 1000);
      chk("rand_sb_left", sb.size(), 0);

      // ---------------- reset mid-burst ----------------
      m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         wr_data = {4{32'hBAD00000 | 32'(i)}};
         wr_keep = 16'hFFFF;
         wr_last = 1'b0;
         tick();
      end
      reset = 1'b1;                            // beat 4 presented with reset
      tick();
      chk("mid_rst_tvalid", m_axis_tvalid, 0);
      chk("mid_rst_empty",  fifo_empty, 1);
      chk("mid_rst_full",   wr_full, 0);
      chk("mid_rst_tdata",  m_axis_tdata, 0);
      reset = 1'b0;
      wr_en = 1'b0;
      seen  = 0;
      for (int i = 0; i < 8; i++) begin
         m_axis_tready = 1'(i);
         tick();
         if (m_axis_tvalid) seen++;
      end
      chk("post_rst_no_stale", seen, 0);

      m_axis_tready = 1'b1;
      wr_en   = 1'b1;
      wr_data = 128'hFEEDFACE_00000001_CAFEF00D_00000002;
      wr_keep = 16'h00FF;
      wr_last = 1'b1;
      tick();
      wr_en = 1'b0;
      tick();
      tick();
      chk("post_rst_beat", out_beat(), {1'b1, 16'h00FF, 128'hFEEDFACE_00000001_CAFEF00D_00000002});
      tick();
      chk("post_rst_tvalid_end", m_axis_tvalid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fifo_axis_bridge.md
# fifo_axis_bridge

Buffered FIFO-to-AXI4-Stream master bridge. A write-side producer pushes beats (data, byte-keep, last flag) into an internal `generic_fifo`. An internal `fifo_to_axis` adapter prefetches those beats into a small skid buffer and presents them as an AXI4-Stream master with full back-pressure support. It sits between packet-building logic (for example IP/UDP framers) and any AXIS consumer.

## Interface
Parameters:
- DATA_WIDTH, 128, tdata width in bits; must be a multiple of 8.
- FIFO_DEPTH, 32, entries in the main FIFO; power of 2.
- BUFFER_DEPTH, 4, skid/prefetch buffer entries in the adapter; 2–8.

Ports (clock and reset first):
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write strobe; accepted when wr_full=0.
- wr_data  in  DATA_WIDTH  beat payload.
- wr_keep  in  DATA_WIDTH/8  byte enables for the beat.
- wr_last  in  1  end-of-packet flag for the beat.
- wr_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  main FIFO holds 0 entries.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tdata  out  DATA_WIDTH  output payload.
- m_axis_tkeep  out  DATA_WIDTH/8  output byte enables.
- m_axis_tlast  out  1  output end-of-packet.
- m_axis_tready  in  1  consumer ready.

## Operation
- generic_fifo (DEPTH, WIDTH):
  - Entry width is DATA_WIDTH + DATA_WIDTH/8 + 1, packed as {last, keep, data}.
  - Circular RAM with log2(DEPTH)-bit read and write pointers that wrap, plus a log2(DEPTH)+1-bit count.
  - Write: wr_en && !full stores the entry at the write pointer and increments it. Writes while full are dropped, including when a read happens in the same cycle.
  - Read: rd_en && !empty registers the entry at the read pointer onto dout, pulses dout_valid for one cycle, and increments the read pointer. Reads while empty are ignored; dout_valid stays 0.
  - Simultaneous accepted read and write leave the count unchanged.
  - empty = (count==0) and full = (count==DEPTH), both registered from count.
- fifo_to_axis (WIDTH, BUFFER_DEPTH):
  - rd_en = !fifo_empty && (occupancy + in_flight) < BUFFER_DEPTH, combinational. in_flight is 1 in the cycle after a read is issued.
  - Each dout_valid writes the entry into the skid buffer, a circular array of BUFFER_DEPTH entries.
  - m_axis_tvalid = buffer not empty. tdata, tkeep and tlast come from the head entry.
  - A pop happens when tvalid && tready. A pop and a capture in the same cycle leave occupancy unchanged.
  - While tvalid=1 and tready=0, tdata, tkeep and tlast hold stable.
- Data integrity: beats exit in write order, bit-exact, with no loss or duplication and no dependence on tready pattern.

## Timing
- Reset (synchronous, takes priority over everything) clears:
  - all pointers, counts and in_flight;
  - m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0;
  - wr_full=0, fifo_empty=1.
- Asserting reset mid-stream discards all buffered beats.
- Latency:
  - Write accepted at edge k → fifo_empty=0 after edge k.
  - rd_en is high in cycle k→k+1, dout_valid after edge k+1, and m_axis_tvalid=1 after edge k+2.
  - First-beat latency is therefore 2 cycles.
- Throughput: with tready held high, sustains 1 beat/cycle once primed.
- Back-pressure:
  - When tready stays 0, the adapter stops issuing reads once the buffer plus in-flight entries reach BUFFER_DEPTH.
  - The FIFO then fills, and wr_full asserts after FIFO_DEPTH beats.
- Boundaries:
  - Pointer wrap at DEPTH-1→0 and BUFFER_DEPTH-1→0 is seamless.
  - The last FIFO entry read sets fifo_empty on the same edge that its dout_valid registers.
  - Write while full: entry dropped, count unchanged.
  - tready rising while the buffer is empty has no effect.

## Test plan
- Reset: hold 100 cycles with random inputs → tvalid=0, fifo_empty=1, wr_full=0, tdata=0.
- Single beat:
  - Stimulus: write {data=0x0123…CDEF, keep=0xFFFF, last=1} at edge k with tready=1.
  - Required: tvalid after edge k+2 for exactly 1 cycle, with matching data/keep/last.
- Burst of 5 PRBS beats (LFSR x³²+x²²+x²+x+1, seed 0xFFFFFFFF) with last on beat 5, tready=1:
  - 5 consecutive valid beats in order; only beat 5 has tlast.
  - fifo_empty=1 afterward.
- Back-pressure:
  - Stimulus: tready=0 while writing 40 beats.
  - Required: wr_full after beat 36 (32 in FIFO + 4 buffered); beats 37–40 dropped; tdata stable while stalled.
  - Then release tready: beats 1–36 emerge in order.
- Random tready (50%) over 1000 beats with random keep/last: a scoreboard matches every beat and wrap-around is exercised.
- Reset mid-burst after 3 of 5 beats → tvalid=0 next cycle, FIFO empty, and no stale beats after reset releases.
